// File: rtl/cci_test_stat_csrs.sv
// cci_test_stat_csrs
// Event-statistics CSR bank for test AFUs. NUM_CTRS counters of CTR_WIDTH
// bits each add a per-cycle increment from evt_inc. Each counter either
// saturates or wraps, and keeps a sticky overflow flag. Software can freeze
// the counters (the read path then shows a snapshot) and clear them.
//
// CSR window (64-bit indices from BASE_CSR_IDX):
//   +0 CTRL   bit0 FREEZE (RW), bit1 CLEAR (write-1 pulse, reads 0)
//   +1 INFO   [7:0] NUM_CTRS, [15:8] CTR_WIDTH, [19:16] INC_WIDTH, [20] SATURATE
//   +2 OVF    sticky overflow flags, one bit per counter
//   +3+i      CTR[i], zero-extended
//
// Ports:
//   clk, reset           sole clock, synchronous active-high reset
//   mmio_rd_valid/_wr_valid, mmio_addr, mmio_tid, mmio_wr_data
//                        decoded MMIO request
//   evt_inc              per-counter increments, INC_WIDTH bits per lane
//   rsp_valid/_tid/_data read response, 2 cycles after the request
module cci_test_stat_csrs #(
  parameter int NUM_CTRS     = 8,
  parameter int CTR_WIDTH    = 48,
  parameter int INC_WIDTH    = 3,
  parameter int SATURATE     = 1,
  parameter int BASE_CSR_IDX = 64,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mmio_rd_valid,
  input  logic                          mmio_wr_valid,
  input  logic [ADDR_WIDTH-1:0]         mmio_addr,
  input  logic [8:0]                    mmio_tid,
  input  logic [63:0]                   mmio_wr_data,
  input  logic [NUM_CTRS*INC_WIDTH-1:0] evt_inc,
  output logic                          rsp_valid,
  output logic [8:0]                    rsp_tid,
  output logic [63:0]                   rsp_data
);

  localparam int WIN_SIZE = 3 + NUM_CTRS;
  localparam int OFF_W    = $clog2(WIN_SIZE);
  // One extra bit above the wider operand catches the carry-out.
  localparam int SUM_W    = ((CTR_WIDTH > INC_WIDTH) ? CTR_WIDTH : INC_WIDTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_CSR_IDX);
  localparam logic [63:0] INFO_VAL = {43'd0, 1'(SATURATE), 4'(INC_WIDTH),
                                      8'(CTR_WIDTH), 8'(NUM_CTRS)};

  // Address decode
  logic [ADDR_WIDTH-1:0] addr_off;
  logic                  in_window;

  assign addr_off  = mmio_addr - BASE;
  assign in_window = (mmio_addr >= BASE) && (addr_off < ADDR_WIDTH'(WIN_SIZE));

  // Only the two CTRL bits of the write data carry meaning.
  logic unused_wr_bits;
  assign unused_wr_bits = ^mmio_wr_data[63:2];

  // Input stage: requests and increments are registered once before use.
  logic                          rd_s1_reg;
  logic                          wr_s1_reg;
  logic [8:0]                    tid_s1_reg;
  logic [OFF_W-1:0]              off_s1_reg;
  logic                          wr_freeze_s1_reg;
  logic                          wr_clear_s1_reg;
  logic [NUM_CTRS*INC_WIDTH-1:0] inc_s1_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_s1_reg        <= 1'b0;
      wr_s1_reg        <= 1'b0;
      tid_s1_reg       <= '0;
      off_s1_reg       <= '0;
      wr_freeze_s1_reg <= 1'b0;
      wr_clear_s1_reg  <= 1'b0;
      inc_s1_reg       <= '0;
    end else begin
      // A write in the same cycle wins; the read is dropped silently.
      rd_s1_reg        <= mmio_rd_valid && !mmio_wr_valid && in_window;
      // Only CTRL is writable, so writes elsewhere are never staged.
      wr_s1_reg        <= mmio_wr_valid && in_window && (addr_off == '0);
      tid_s1_reg       <= mmio_tid;
      off_s1_reg       <= addr_off[OFF_W-1:0];
      wr_freeze_s1_reg <= mmio_wr_data[0];
      wr_clear_s1_reg  <= mmio_wr_data[1];
      inc_s1_reg       <= evt_inc;
    end
  end

  // Control and snapshot
  logic                          freeze_reg;
  logic                          clear_pulse;
  logic                          snap_load;
  logic [NUM_CTRS*CTR_WIDTH-1:0] live_ctr_flat;
  logic [NUM_CTRS-1:0]           live_ovf;
  logic [NUM_CTRS*CTR_WIDTH-1:0] snap_ctr_reg;
  logic [NUM_CTRS-1:0]           snap_ovf_reg;

  assign clear_pulse = wr_s1_reg && wr_clear_s1_reg;
  // Snapshot only on the 0->1 edge of FREEZE; it samples the live values
  // before this edge's clear or increment lands.
  assign snap_load   = wr_s1_reg && wr_freeze_s1_reg && !freeze_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      freeze_reg   <= 1'b0;
      snap_ctr_reg <= '0;
      snap_ovf_reg <= '0;
    end else begin
      if (wr_s1_reg) begin
        freeze_reg <= wr_freeze_s1_reg;
      end
      if (snap_load) begin
        snap_ctr_reg <= live_ctr_flat;
        snap_ovf_reg <= live_ovf;
      end
    end
  end

  // Live counters
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRS; gi++) begin : g_ctr
      logic [CTR_WIDTH-1:0] ctr_reg;
      logic                 ovf_reg;
      logic [SUM_W-1:0]     sum;
      logic                 carry;

      assign sum   = SUM_W'(ctr_reg) + SUM_W'(inc_s1_reg[gi*INC_WIDTH +: INC_WIDTH]);
      assign carry = (sum >> CTR_WIDTH) != '0;

      always_ff @(posedge clk) begin
        if (reset || clear_pulse) begin
          // A clear also discards the increment staged in the same cycle.
          ctr_reg <= '0;
          ovf_reg <= 1'b0;
        end else begin
          if (carry && (SATURATE != 0)) begin
            ctr_reg <= '1;
          end else begin
            ctr_reg <= sum[CTR_WIDTH-1:0];
          end
          if (carry) begin
            ovf_reg <= 1'b1;
          end
        end
      end

      assign live_ctr_flat[gi*CTR_WIDTH +: CTR_WIDTH] = ctr_reg;
      assign live_ovf[gi]                             = ovf_reg;
    end
  endgenerate

  // Read data selection, one cycle after the request.
  logic [63:0] rd_data_next;

  always_comb begin
    rd_data_next = '0;
    if (off_s1_reg == OFF_W'(0)) begin
      rd_data_next = {63'd0, freeze_reg};
    end else if (off_s1_reg == OFF_W'(1)) begin
      rd_data_next = INFO_VAL;
    end else if (off_s1_reg == OFF_W'(2)) begin
      rd_data_next = 64'(freeze_reg ? snap_ovf_reg : live_ovf);
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        if (off_s1_reg == OFF_W'(i + 3)) begin
          rd_data_next = 64'(freeze_reg ? snap_ctr_reg[i*CTR_WIDTH +: CTR_WIDTH]
                                        : live_ctr_flat[i*CTR_WIDTH +: CTR_WIDTH]);
        end
      end
    end
  end

  // Response stage
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rd_s1_reg;
      if (rd_s1_reg) begin
        rsp_tid  <= tid_s1_reg;
        rsp_data <= rd_data_next;
      end
    end
  end

endmodule

// File: tb/tb_cci_test_stat_csrs.sv
// Bench for cci_test_stat_csrs: one default-parameter instance plus two
// 4-bit-counter instances (saturating and wrapping) sharing the MMIO bus.
module tb_cci_test_stat_csrs;

  logic        clk;
  logic        reset;
  logic        mmio_rd_valid;
  logic        mmio_wr_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic [23:0] evt_m;
  logic [5:0]  evt_s;

  logic [2:0]        rv;
  logic [2:0][8:0]   rt;
  logic [2:0][63:0]  rdt;

  int checks = 0;
  int errors = 0;
  logic [8:0] tid_cnt = 9'd0;

  cci_test_stat_csrs u_main (
    .clk(clk), .reset(reset), .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .evt_inc(evt_m), .rsp_valid(rv[0]), .rsp_tid(rt[0]), .rsp_data(rdt[0])
  );

  cci_test_stat_csrs #(.NUM_CTRS(2), .CTR_WIDTH(4), .INC_WIDTH(3), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .evt_inc(evt_s), .rsp_valid(rv[1]), .rsp_tid(rt[1]), .rsp_data(rdt[1])
  );

  cci_test_stat_csrs #(.NUM_CTRS(2), .CTR_WIDTH(4), .INC_WIDTH(3), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wr_data(mmio_wr_data),
    .evt_inc(evt_s), .rsp_valid(rv[2]), .rsp_tid(rt[2]), .rsp_data(rdt[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mmio_rd_valid = 1'b0;
    mmio_wr_valid = 1'b0;
    evt_m = '0;
    evt_s = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_valid = 1'b1;
    mmio_addr = a;
    mmio_wr_data = d;
    @(negedge clk);
    mmio_wr_valid = 1'b0;
    $display("wr addr %0d data 0x%0h", a, d);
  endtask

  // Issue one read and check the response of instance d two cycles later.
  task automatic read_chk(input int d, input logic [15:0] a, input logic [63:0] exp,
                          input string name);
    tid_cnt = tid_cnt + 9'd1;
    mmio_rd_valid = 1'b1;
    mmio_addr = a;
    mmio_tid = tid_cnt;
    @(negedge clk);
    mmio_rd_valid = 1'b0;
    chk({name, "_early"}, 64'(rv[d]), 64'd0);
    @(negedge clk);
    chk({name, "_valid"}, 64'(rv[d]), 64'd1);
    chk({name, "_tid"}, 64'(rt[d]), 64'(tid_cnt));
    chk(name, rdt[d], exp);
    $display("rd dut%0d addr %0d tid %0d data 0x%0h", d, a, rt[d], rdt[d]);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [63:0] wdata;
    logic        exp_rsp;
    logic [63:0] exp_data;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  longint unsigned tot_m [8];
  longint unsigned tot_s [2];

  function automatic logic [63:0] sat4(input longint unsigned t);
    return (t > 15) ? 64'd15 : 64'(t);
  endfunction

  initial begin
    logic [31:0] v;
    logic [5:0]  vs;
    logic [63:0] exp_ovf;
    int k_cycles;

    vecs[0]  = '{16'd64, 1'b0, 64'd0,      1'b1, 64'd0};
    vecs[1]  = '{16'd65, 1'b0, 64'd0,      1'b1, 64'h0013_3008};
    vecs[2]  = '{16'd66, 1'b0, 64'd0,      1'b1, 64'd0};
    vecs[3]  = '{16'd67, 1'b0, 64'd0,      1'b1, 64'd0};
    vecs[4]  = '{16'd74, 1'b0, 64'd0,      1'b1, 64'd0};
    vecs[5]  = '{16'd63, 1'b0, 64'd0,      1'b0, 64'd0};
    vecs[6]  = '{16'd75, 1'b0, 64'd0,      1'b0, 64'd0};
    vecs[7]  = '{16'd64, 1'b1, 64'd1,      1'b0, 64'd0};
    vecs[8]  = '{16'd64, 1'b0, 64'd0,      1'b1, 64'd1};
    vecs[9]  = '{16'd64, 1'b1, 64'd2,      1'b0, 64'd0};
    vecs[10] = '{16'd64, 1'b0, 64'd0,      1'b1, 64'd0};
    vecs[11] = '{16'd65, 1'b1, 64'hFFFF,   1'b0, 64'd0};
    vecs[12] = '{16'd65, 1'b0, 64'd0,      1'b1, 64'h0013_3008};

    mmio_addr = '0;
    mmio_tid = '0;
    mmio_wr_data = '0;
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rv[0]), 64'd0);
    chk("reset_rsp_tid", 64'(rt[0]), 64'd0);
    chk("reset_rsp_data", rdt[0], 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven register access
    for (int k = 0; k < NV; k++) begin
      tid_cnt = tid_cnt + 9'd1;
      mmio_rd_valid = 1'b1;
      mmio_wr_valid = vecs[k].wr;
      mmio_addr = vecs[k].addr;
      mmio_wr_data = vecs[k].wdata;
      mmio_tid = tid_cnt;
      @(negedge clk);
      mmio_rd_valid = 1'b0;
      mmio_wr_valid = 1'b0;
      chk($sformatf("vec%0d_early", k), 64'(rv[0]), 64'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), 64'(rv[0]), 64'(vecs[k].exp_rsp));
      if (vecs[k].exp_rsp) begin
        chk($sformatf("vec%0d_tid", k), 64'(rt[0]), 64'(tid_cnt));
        chk($sformatf("vec%0d_data", k), rdt[0], vecs[k].exp_data);
      end
      $display("vec %0d addr %0d wr %0d rsp %0d data 0x%0h", k, vecs[k].addr, vecs[k].wr,
               rv[0], rdt[0]);
    end

    // Lane 2 = 5 for 10 cycles
    do_reset();
    evt_m = 24'h000140;
    idle(10);
    evt_m = '0;
    idle(2);
    for (int i = 0; i < 8; i++) begin
      read_chk(0, 16'(67 + i), (i == 2) ? 64'd50 : 64'd0, $sformatf("laneA_ctr%0d", i));
    end

    // 4-bit counters, lane 0 = 7 for 3 cycles
    do_reset();
    read_chk(1, 16'd65, 64'h0013_0402, "sat_info");
    read_chk(2, 16'd65, 64'h0003_0402, "wrap_info");
    evt_s = 6'd7;
    idle(3);
    evt_s = '0;
    idle(4);
    read_chk(1, 16'd67, 64'hF, "sat_ctr0");
    read_chk(1, 16'd66, 64'h1, "sat_ovf");
    read_chk(2, 16'd67, 64'h5, "wrap_ctr0");
    read_chk(2, 16'd66, 64'h1, "wrap_ovf");
    wr(16'd64, 64'd2);
    read_chk(1, 16'd66, 64'h0, "sat_ovf_cleared");
    read_chk(2, 16'd67, 64'h0, "wrap_ctr_cleared");

    // Freeze / snapshot
    do_reset();
    evt_m = 24'h000020;
    idle(5);
    evt_m = '0;
    idle(2);
    read_chk(0, 16'd68, 64'd20, "frz_live20");
    wr(16'd64, 64'd1);
    evt_m = 24'h000008;
    for (int i = 0; i < 5; i++) begin
      read_chk(0, 16'd68, 64'd20, $sformatf("frz_snap%0d", i));
    end
    evt_m = '0;
    idle(2);
    wr(16'd64, 64'd0);
    read_chk(0, 16'd68, 64'd30, "frz_live30");

    // Freeze + clear together
    wr(16'd64, 64'd3);
    read_chk(0, 16'd64, 64'd1, "fc_ctrl");
    read_chk(0, 16'd68, 64'd30, "fc_snap30");
    read_chk(0, 16'd66, 64'd0, "fc_ovf");
    evt_m = 24'h000008;
    idle(4);
    evt_m = '0;
    idle(2);
    read_chk(0, 16'd68, 64'd30, "fc_still_frozen");
    wr(16'd64, 64'd0);
    read_chk(0, 16'd68, 64'd4, "fc_live4");

    // Reset one cycle after a read
    tid_cnt = tid_cnt + 9'd1;
    mmio_rd_valid = 1'b1;
    mmio_addr = 16'd68;
    mmio_tid = tid_cnt;
    @(negedge clk);
    mmio_rd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_no_rsp", 64'(rv[0]), 64'd0);
    @(negedge clk);
    chk("rstmid_no_rsp_late", 64'(rv[0]), 64'd0);
    $display("rd dut0 addr 68 dropped by reset");
    read_chk(0, 16'd68, 64'd0, "rstmid_ctr_zero");

    // Randomized increments against arithmetic totals
    do_reset();
    for (int i = 0; i < 8; i++) tot_m[i] = 0;
    for (int i = 0; i < 2; i++) tot_s[i] = 0;
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr(16'd64, 64'd2);
        for (int i = 0; i < 8; i++) tot_m[i] = 0;
        for (int i = 0; i < 2; i++) tot_s[i] = 0;
      end
      k_cycles = $urandom_range(1, 20);
      for (int c = 0; c < k_cycles; c++) begin
        v = $urandom;
        vs = 6'($urandom_range(0, 63));
        evt_m = v[23:0];
        evt_s = vs;
        for (int i = 0; i < 8; i++) tot_m[i] += longint'((v >> (3 * i)) & 32'h7);
        for (int i = 0; i < 2; i++) tot_s[i] += longint'((vs >> (3 * i)) & 6'h7);
        @(negedge clk);
      end
      evt_m = '0;
      evt_s = '0;
      idle(2);
      for (int i = 0; i < 8; i++) begin
        read_chk(0, 16'(67 + i), 64'(tot_m[i]), $sformatf("rnd%0d_m%0d", r, i));
      end
      read_chk(0, 16'd66, 64'd0, $sformatf("rnd%0d_m_ovf", r));
      exp_ovf = '0;
      for (int i = 0; i < 2; i++) begin
        read_chk(1, 16'(67 + i), sat4(tot_s[i]), $sformatf("rnd%0d_sat%0d", r, i));
        read_chk(2, 16'(67 + i), 64'(tot_s[i] % 16), $sformatf("rnd%0d_wrap%0d", r, i));
        if (tot_s[i] > 15) exp_ovf[i] = 1'b1;
      end
      read_chk(1, 16'd66, exp_ovf, $sformatf("rnd%0d_sat_ovf", r));
      read_chk(2, 16'd66, exp_ovf, $sformatf("rnd%0d_wrap_ovf", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cci_test_stat_csrs.md
# cci_test_stat_csrs

Parametrised event-statistics CSR bank for MPF test AFUs: a successor to the fixed per-test counter set, with configurable counter count, counter width and per-cycle increment width. Sits beside the generic test CSR manager on the decoded MMIO path and counts per-cycle events from the test datapath. Adds two behaviours the fixed set lacks:
- software freeze/snapshot plus clear-all;
- sticky saturate-or-wrap overflow flags.

## Interface
Parameters:
- NUM_CTRS, 8, number of counters (1..64)
- CTR_WIDTH, 48, counter width in bits (1..64)
- INC_WIDTH, 3, width of each per-cycle increment (1..8)
- SATURATE, 1, 1 = counters stick at max; 0 = counters wrap
- BASE_CSR_IDX, 64, 64-bit CSR index of the first register in the window
- ADDR_WIDTH, 16, width of the CSR index

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- mmio_rd_valid  in  1  read request this cycle
- mmio_wr_valid  in  1  write request this cycle
- mmio_addr  in  ADDR_WIDTH  64-bit CSR index
- mmio_tid  in  9  read transaction ID
- mmio_wr_data  in  64  write data
- evt_inc  in  NUM_CTRS*INC_WIDTH  per-counter increment; counter i uses bits [i*INC_WIDTH +: INC_WIDTH]
- rsp_valid  out  1  read response valid
- rsp_tid  out  9  echoed TID
- rsp_data  out  64  read data

## Operation
- Window: BASE_CSR_IDX ≤ mmio_addr < BASE_CSR_IDX+3+NUM_CTRS. Requests outside the window are ignored and produce no response.
- Offset 0, CTRL (RW):
  - bit0 FREEZE;
  - bit1 CLEAR, write-1 pulse, always reads 0;
  - other bits read 0.
- Offset 1, INFO (RO): [7:0] NUM_CTRS, [15:8] CTR_WIDTH, [19:16] INC_WIDTH, [20] SATURATE, others 0.
- Offset 2, OVF (RO): bit i is the sticky overflow flag of counter i; bits ≥ NUM_CTRS read 0.
- Offset 3+i, CTR[i] (RO): counter i, zero-extended to 64 bits.
- Writes to RO offsets are discarded.
- Simultaneous rd and wr: the write is performed and the read is dropped with no response.
- Increments: evt_inc is registered one stage, then added to counter i after zero-extension to CTR_WIDTH.
- Overflow, SATURATE=1: if the sum exceeds 2^CTR_WIDTH−1, the counter loads all-ones and OVF[i] is set.
- Overflow, SATURATE=0: the counter keeps the sum mod 2^CTR_WIDTH; OVF[i] is set on carry-out.
- OVF bits are sticky until CLEAR or reset.
- FREEZE 0→1 write: the snapshot register array loads the live counter and OVF values. Live counters keep counting.
- FREEZE read selection: while FREEZE=1, reads of CTR[i] and OVF return snapshot values; while FREEZE=0 they return live values.
- Writing FREEZE=1 while it is already 1 does not re-snapshot.
- CLEAR=1 write: live counters and live OVF are zeroed. Increments registered in that cycle are discarded.
- CLEAR and FREEZE 0→1 in the same write: the snapshot captures the pre-clear values.

## Timing
- Reset values: all counters, OVF, snapshot, CTRL and the pipeline valids are 0; rsp_valid=0; rsp_tid=0; rsp_data=0.
- Increment latency: evt_inc in cycle t appears in the counter value from cycle t+2.
- Read latency: fixed at 2 cycles. A read in cycle r gives rsp_valid=1 in cycle r+2 only; data is the selected value held during cycle r+1.
- Read throughput: one read per cycle, fully pipelined, no backpressure.
- Write effect: a write in cycle w updates CTRL/counters at the edge ending w+1's input stage. A read issued in cycle w+1 sees the post-write state.
- Reset mid-operation: in-flight reads are dropped, no response. Reset has priority over every update in the same cycle.

## Test plan
- Reset, then read offsets 0/1/2/3 with NUM_CTRS=8, CTR_WIDTH=48, INC_WIDTH=3, SATURATE=1 -> 0x0, 0x0013_3008, 0x0, 0x0; each response arrives 2 cycles after its request with matching TID.
- Drive evt_inc lane 2 = 5 for 10 cycles, then idle -> CTR[2]=50 and all other counters 0.
- CTR_WIDTH=4, SATURATE=1, lane 0 = 7 for 3 cycles -> CTR[0]=0xF and OVF=0x1. Repeat with SATURATE=0 -> CTR[0]=0x5 and OVF=0x1.
- FREEZE/snapshot:
  - count lane 1 to 20, then write CTRL=0x1 and keep incrementing by 1 for 10 cycles;
  - reads of CTR[1] return 20;
  - write CTRL=0x0, read -> 30.
- Write CTRL=0x3 with CTR[1]=30 -> a frozen read returns 30; write CTRL=0x0, read -> 0 plus the increments since the clear.
- Reset asserted one cycle after a read; read outside the window; simultaneous rd+wr -> no response in each case. The write still takes effect.
